// File: rtl/univ_shift_reg_n.sv
// rtl/univ_shift_reg_n.sv - universal shift register with command handshake
// One command per operation; multi-bit shifts run one bit per clock.
module univ_shift_reg_n #(
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [AW-1:0]    cmd_amt,
  input  logic [WIDTH-1:0] load_data,
  input  logic             sr_in,
  input  logic             sl_in,
  output logic [WIDTH-1:0] q,
  output logic             sr_out,
  output logic             sl_out,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_SHR  = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_LOAD = 3'b011;
  localparam logic [2:0] OP_ROR  = 3'b100;
  localparam logic [2:0] OP_ROL  = 3'b101;
  localparam logic [2:0] OP_ASR  = 3'b110;
  localparam logic [2:0] OP_CLR  = 3'b111;

  localparam logic [AW-1:0] AMT_MAX = AW'(WIDTH);
  localparam logic [AW-1:0] AMT_ONE = AW'(1);

  // One-hot encoding so a corrupted state is detectable and recovers to IDLE
  typedef enum logic [1:0] {
    S_IDLE = 2'b01,
    S_RUN  = 2'b10
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic [AW-1:0]    count, count_nxt;
  logic [AW-1:0]    amt_n;
  logic [2:0]       op_r, op_nxt;
  logic             done_nxt;

  function automatic logic [WIDTH-1:0] shift_step(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] v,
    input logic             sr,
    input logic             sl
  );
    logic [WIDTH-1:0] r;
    case (op)
      OP_SHR:  r = {sr, v[WIDTH-1:1]};
      OP_SHL:  r = {v[WIDTH-2:0], sl};
      OP_ROR:  r = {v[0], v[WIDTH-1:1]};
      OP_ROL:  r = {v[WIDTH-2:0], v[WIDTH-1]};
      OP_ASR:  r = {v[WIDTH-1], v[WIDTH-1:1]};
      default: r = v;
    endcase
    return r;
  endfunction

  assign amt_n     = (cmd_amt > AMT_MAX) ? AMT_MAX : cmd_amt;
  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state == S_RUN);
  assign sr_out    = q[0];
  assign sl_out    = q[WIDTH-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      q     <= '0;
      count <= '0;
      op_r  <= OP_HOLD;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      q     <= q_nxt;
      count <= count_nxt;
      op_r  <= op_nxt;
      done  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    q_nxt     = q;
    count_nxt = count;
    op_nxt    = op_r;
    done_nxt  = 1'b0;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_HOLD: done_nxt = 1'b1;
            OP_LOAD: begin
              q_nxt    = load_data;
              done_nxt = 1'b1;
            end
            OP_CLR: begin
              q_nxt    = '0;
              done_nxt = 1'b1;
            end
            default: begin
              if (amt_n == '0) begin
                done_nxt = 1'b1;
              end else begin
                // First step lands on the accept edge itself
                q_nxt     = shift_step(cmd_op, q, sr_in, sl_in);
                count_nxt = amt_n - AMT_ONE;
                op_nxt    = cmd_op;
                if (amt_n == AMT_ONE) done_nxt = 1'b1;
                else                  state_nxt = S_RUN;
              end
            end
          endcase
        end
      end
      S_RUN: begin
        q_nxt = shift_step(op_r, q, sr_in, sl_in);
        if (count <= AMT_ONE) begin
          count_nxt = '0;
          state_nxt = S_IDLE;
          done_nxt  = 1'b1;
        end else begin
          count_nxt = count - AMT_ONE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        count_nxt = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_univ_shift_reg_n.sv
// tb/tb_univ_shift_reg_n.sv - directed table-driven bench for univ_shift_reg_n
module tb_univ_shift_reg_n;

  localparam int WIDTH = 8;
  localparam int AW    = 4;

  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_SHR  = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_LOAD = 3'b011;
  localparam logic [2:0] OP_ROR  = 3'b100;
  localparam logic [2:0] OP_ROL  = 3'b101;
  localparam logic [2:0] OP_ASR  = 3'b110;
  localparam logic [2:0] OP_CLR  = 3'b111;

  logic             clk = 1'b0;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [AW-1:0]    cmd_amt;
  logic [WIDTH-1:0] load_data;
  logic             sr_in;
  logic             sl_in;
  logic [WIDTH-1:0] q;
  logic             sr_out;
  logic             sl_out;
  logic             busy;
  logic             done;

  int n_pass = 0;
  int n_total = 0;

  univ_shift_reg_n #(.WIDTH(WIDTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_amt(cmd_amt), .load_data(load_data),
    .sr_in(sr_in), .sl_in(sl_in), .q(q), .sr_out(sr_out), .sl_out(sl_out),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]    op;
    logic [AW-1:0] amt;
    logic [7:0]    data;
    logic          sr;
    logic          sl;
    logic [7:0]    exp_q;
    int            exp_lat;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  // Present a command before the next edge; returns after the accept edge (+1)
  task automatic issue(input logic [2:0] op, input logic [AW-1:0] amt,
                       input logic [7:0] data, input logic sr, input logic sl);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_amt   = amt;
    load_data = data;
    sr_in     = sr;
    sl_in     = sl;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  initial begin
    int lat;

    vecs[0]  = '{OP_LOAD, 4'd0,  8'hA5, 1'b0, 1'b0, 8'hA5, 1};
    vecs[1]  = '{OP_SHR,  4'd3,  8'h00, 1'b1, 1'b0, 8'hF4, 3};
    vecs[2]  = '{OP_LOAD, 4'd0,  8'h81, 1'b0, 1'b0, 8'h81, 1};
    vecs[3]  = '{OP_ROL,  4'd8,  8'h00, 1'b0, 1'b0, 8'h81, 8};
    vecs[4]  = '{OP_ROL,  4'd12, 8'h00, 1'b0, 1'b0, 8'h81, 8};
    vecs[5]  = '{OP_LOAD, 4'd0,  8'h80, 1'b0, 1'b0, 8'h80, 1};
    vecs[6]  = '{OP_ASR,  4'd2,  8'h00, 1'b0, 1'b0, 8'hE0, 2};
    vecs[7]  = '{OP_SHL,  4'd1,  8'h00, 1'b0, 1'b1, 8'hC1, 1};
    vecs[8]  = '{OP_SHL,  4'd0,  8'h00, 1'b0, 1'b1, 8'hC1, 1};
    vecs[9]  = '{OP_ROR,  4'd1,  8'h00, 1'b0, 1'b0, 8'hE0, 1};
    vecs[10] = '{OP_HOLD, 4'd5,  8'h33, 1'b1, 1'b1, 8'hE0, 1};
    vecs[11] = '{OP_SHR,  4'd4,  8'h00, 1'b0, 1'b0, 8'h0E, 4};
    vecs[12] = '{OP_CLR,  4'd0,  8'hFF, 1'b0, 1'b0, 8'h00, 1};

    reset = 1'b1; cmd_valid = 1'b0; cmd_op = OP_HOLD; cmd_amt = '0;
    load_data = '0; sr_in = 1'b0; sl_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_q", 32'(q), 32'h00);
    check("reset_ready", 32'(cmd_ready), 32'h1);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      issue(vecs[i].op, vecs[i].amt, vecs[i].data, vecs[i].sr, vecs[i].sl);
      wait_done(lat);
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("vec%0d_q", i), 32'(q), 32'(vecs[i].exp_q));
      check($sformatf("vec%0d_ready", i), 32'(cmd_ready), 32'h1);
      check($sformatf("vec%0d_sr_out", i), 32'(sr_out), 32'(vecs[i].exp_q[0]));
      check($sformatf("vec%0d_sl_out", i), 32'(sl_out), 32'(vecs[i].exp_q[7]));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_done_pulse", i), 32'(done), 32'h0);
    end

    // SHR by 3 step by step, with busy/done timing
    issue(OP_LOAD, 4'd0, 8'hA5, 1'b1, 1'b0);
    issue(OP_SHR, 4'd3, 8'h00, 1'b1, 1'b0);
    check("shr_e0_q", 32'(q), 32'hD2);
    check("shr_e0_busy", 32'(busy), 32'h1);
    check("shr_e0_ready", 32'(cmd_ready), 32'h0);
    @(posedge clk); #1;
    check("shr_e1_q", 32'(q), 32'hE9);
    check("shr_e1_busy", 32'(busy), 32'h1);
    check("shr_e1_done", 32'(done), 32'h0);
    @(posedge clk); #1;
    check("shr_e2_q", 32'(q), 32'hF4);
    check("shr_e2_busy", 32'(busy), 32'h0);
    check("shr_e2_done", 32'(done), 32'h1);

    // Zero-distance shift then CLR accepted in the done cycle
    issue(OP_LOAD, 4'd0, 8'h5A, 1'b0, 1'b0);
    issue(OP_SHL, 4'd0, 8'h00, 1'b0, 1'b1);
    check("shl0_q", 32'(q), 32'h5A);
    check("shl0_done", 32'(done), 32'h1);
    cmd_valid = 1'b1; cmd_op = OP_CLR;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("b2b_clr_q", 32'(q), 32'h00);
    check("b2b_clr_done", 32'(done), 32'h1);

    // Reset in the middle of a rotate
    issue(OP_LOAD, 4'd0, 8'h3C, 1'b0, 1'b0);
    issue(OP_ROR, 4'd6, 8'h00, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("ror_mid_busy", 32'(busy), 32'h1);
    reset = 1'b1;
    #1;
    check("abort_q", 32'(q), 32'h00);
    check("abort_busy", 32'(busy), 32'h0);
    cmd_valid = 1'b1; cmd_op = OP_LOAD; load_data = 8'hFF;
    repeat (2) begin
      @(posedge clk); #1;
      check("abort_no_done", 32'(done), 32'h0);
    end
    cmd_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("post_reset_ready", 32'(cmd_ready), 32'h1);
    check("post_reset_q", 32'(q), 32'h00);
    check("post_reset_done", 32'(done), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
